// File: rtl/toy_bus_core_initiator.sv
// Core-to-bus initiator: one-entry request and response registers with outstanding-read tracking.
// Optional read watchdog is compiled in when TOY_BUS_INIT_TIMEOUT_EN is defined.
module toy_bus_core_initiator #(
  parameter logic [3:0]  NODE_ID   = 4'd1,
  parameter logic [3:0]  TGT_ID    = 4'd0,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_req_vld,
  output logic         core_req_rdy,
  input  logic [31:0]  core_req_addr,
  input  logic         core_req_wr,
  input  logic [255:0] core_req_wdata,
  input  logic [31:0]  core_req_strb,
  input  logic [9:0]   core_req_tag,
  output logic         core_rsp_vld,
  input  logic         core_rsp_rdy,
  output logic [255:0] core_rsp_rdata,
  output logic [9:0]   core_rsp_tag,
  output logic         out0_req_vld,
  input  logic         out0_req_rdy,
  output logic [31:0]  out0_req_addr,
  output logic [31:0]  out0_req_strb,
  output logic [255:0] out0_req_data,
  output logic         out0_req_opcode,
  output logic [3:0]   out0_req_src_id,
  output logic [3:0]   out0_req_tgt_id,
  output logic [9:0]   out0_req_sideband,
  input  logic         out0_ack_vld,
  output logic         out0_ack_rdy,
  input  logic         out0_ack_opcode,
  input  logic [255:0] out0_ack_data,
  input  logic [9:0]   out0_ack_sideband,
  input  logic [3:0]   out0_ack_src_id,
  input  logic [3:0]   out0_ack_tgt_id,
  output logic         err_unexp,
  output logic         timeout_err
);

  localparam logic [3:0] MaxOutst = MAX_OUTST[3:0];

  logic         reqVld_q;
  logic [31:0]  reqAddr_q;
  logic [31:0]  reqStrb_q;
  logic [255:0] reqData_q;
  logic         reqOpcode_q;
  logic [9:0]   reqTag_q;
  logic         rspVld_q;
  logic [255:0] rspData_q;
  logic [9:0]   rspTag_q;
  logic [3:0]   outstCnt_q;
  logic [3:0]   outstCnt_d;
  logic         errUnexp_q;
  logic         reqLoad;
  logic         readInc;
  logic         ackAccept;
  logic         ackMatch;
  logic         unusedAckBits;

  assign unusedAckBits = ^{out0_ack_opcode, out0_ack_src_id};

  assign core_req_rdy = (!reqVld_q || out0_req_rdy) && (core_req_wr || (outstCnt_q < MaxOutst));
  assign reqLoad      = core_req_vld && core_req_rdy;
  assign readInc      = reqLoad && !core_req_wr;

  // An ack only counts if it is ours and some read is (or is just becoming) outstanding.
  assign out0_ack_rdy = !rspVld_q || core_rsp_rdy;
  assign ackAccept    = out0_ack_vld && out0_ack_rdy;
  assign ackMatch     = ackAccept && (out0_ack_tgt_id == NODE_ID) &&
                        ((outstCnt_q != 4'd0) || readInc);

  always_comb begin
    outstCnt_d = outstCnt_q;
    case ({readInc, ackMatch})
      2'b10:   outstCnt_d = outstCnt_q + 4'd1;
      2'b01:   outstCnt_d = outstCnt_q - 4'd1;
      default: outstCnt_d = outstCnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqVld_q    <= 1'b0;
      reqAddr_q   <= '0;
      reqStrb_q   <= '0;
      reqData_q   <= '0;
      reqOpcode_q <= 1'b0;
      reqTag_q    <= '0;
      rspVld_q    <= 1'b0;
      rspData_q   <= '0;
      rspTag_q    <= '0;
      outstCnt_q  <= '0;
      errUnexp_q  <= 1'b0;
    end else begin
      if (reqLoad) begin
        reqVld_q    <= 1'b1;
        reqAddr_q   <= core_req_addr;
        reqStrb_q   <= core_req_strb;
        reqData_q   <= core_req_wdata;
        reqOpcode_q <= core_req_wr;
        reqTag_q    <= core_req_tag;
      end else if (out0_req_rdy) begin
        reqVld_q <= 1'b0;
      end
      if (ackMatch) begin
        rspVld_q  <= 1'b1;
        rspData_q <= out0_ack_data;
        rspTag_q  <= out0_ack_sideband;
      end else if (core_rsp_rdy) begin
        rspVld_q <= 1'b0;
      end
      outstCnt_q <= outstCnt_d;
      errUnexp_q <= ackAccept && !ackMatch;
    end
  end

  assign out0_req_vld      = reqVld_q;
  assign out0_req_addr     = reqAddr_q;
  assign out0_req_strb     = reqStrb_q;
  assign out0_req_data     = reqData_q;
  assign out0_req_opcode   = reqOpcode_q;
  assign out0_req_sideband = reqTag_q;
  assign out0_req_src_id   = NODE_ID;
  assign out0_req_tgt_id   = TGT_ID;
  assign core_rsp_vld      = rspVld_q;
  assign core_rsp_rdata    = rspData_q;
  assign core_rsp_tag      = rspTag_q;
  assign err_unexp         = errUnexp_q;

`ifdef TOY_BUS_INIT_TIMEOUT_EN
  logic [15:0] toCnt_q;
  logic        timeoutErr_q;

  // Watchdog runs only while reads are outstanding and no matching ack arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt_q      <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      if (ackMatch || (outstCnt_q == 4'd0)) begin
        toCnt_q <= '0;
      end else begin
        toCnt_q <= toCnt_q + 16'd1;
      end
      if (toCnt_q == 16'd1024) begin
        timeoutErr_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeoutErr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_toy_bus_core_initiator.sv
// Directed self-checking bench for toy_bus_core_initiator (default parameters).
// Watchdog expectations follow TOY_BUS_INIT_TIMEOUT_EN.
module tb_toy_bus_core_initiator;

  logic         clk;
  logic         rst;
  logic         core_req_vld;
  logic         core_req_rdy;
  logic [31:0]  core_req_addr;
  logic         core_req_wr;
  logic [255:0] core_req_wdata;
  logic [31:0]  core_req_strb;
  logic [9:0]   core_req_tag;
  logic         core_rsp_vld;
  logic         core_rsp_rdy;
  logic [255:0] core_rsp_rdata;
  logic [9:0]   core_rsp_tag;
  logic         out0_req_vld;
  logic         out0_req_rdy;
  logic [31:0]  out0_req_addr;
  logic [31:0]  out0_req_strb;
  logic [255:0] out0_req_data;
  logic         out0_req_opcode;
  logic [3:0]   out0_req_src_id;
  logic [3:0]   out0_req_tgt_id;
  logic [9:0]   out0_req_sideband;
  logic         out0_ack_vld;
  logic         out0_ack_rdy;
  logic         out0_ack_opcode;
  logic [255:0] out0_ack_data;
  logic [9:0]   out0_ack_sideband;
  logic [3:0]   out0_ack_src_id;
  logic [3:0]   out0_ack_tgt_id;
  logic         err_unexp;
  logic         timeout_err;

  int assertCount = 0;
  int failCount   = 0;

  toy_bus_core_initiator dut (
    .clk(clk), .rst(rst),
    .core_req_vld(core_req_vld), .core_req_rdy(core_req_rdy),
    .core_req_addr(core_req_addr), .core_req_wr(core_req_wr),
    .core_req_wdata(core_req_wdata), .core_req_strb(core_req_strb),
    .core_req_tag(core_req_tag),
    .core_rsp_vld(core_rsp_vld), .core_rsp_rdy(core_rsp_rdy),
    .core_rsp_rdata(core_rsp_rdata), .core_rsp_tag(core_rsp_tag),
    .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy),
    .out0_req_addr(out0_req_addr), .out0_req_strb(out0_req_strb),
    .out0_req_data(out0_req_data), .out0_req_opcode(out0_req_opcode),
    .out0_req_src_id(out0_req_src_id), .out0_req_tgt_id(out0_req_tgt_id),
    .out0_req_sideband(out0_req_sideband),
    .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy),
    .out0_ack_opcode(out0_ack_opcode), .out0_ack_data(out0_ack_data),
    .out0_ack_sideband(out0_ack_sideband), .out0_ack_src_id(out0_ack_src_id),
    .out0_ack_tgt_id(out0_ack_tgt_id),
    .err_unexp(err_unexp), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic wr, input logic [31:0] addr,
                               input logic [9:0] tag, input logic [31:0] strb, input logic [255:0] wdata);
    core_req_vld   = vld;
    core_req_wr    = wr;
    core_req_addr  = addr;
    core_req_tag   = tag;
    core_req_strb  = strb;
    core_req_wdata = wdata;
    #1;
  endtask

  task automatic driveAck(input logic vld, input logic [3:0] tgt, input logic [9:0] tag, input logic [255:0] data);
    out0_ack_vld      = vld;
    out0_ack_tgt_id   = tgt;
    out0_ack_sideband = tag;
    out0_ack_data     = data;
    out0_ack_opcode   = 1'b0;
    out0_ack_src_id   = 4'd0;
    #1;
  endtask

  initial begin
    logic [255:0] wpat;
    int n;
    wpat = {8{32'hDEAD_BEEF}};
    rst = 1'b1;
    out0_req_rdy = 1'b0;
    core_rsp_rdy = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 10'h0, 32'h0, '0);
    driveAck(1'b0, 4'd0, 10'h0, '0);
    repeat (3) tick();

    checkOutput("rst_req_vld", out0_req_vld, 1'b0);
    checkOutput("rst_rsp_vld", core_rsp_vld, 1'b0);
    checkOutput("rst_err_unexp", err_unexp, 1'b0);
    checkOutput("rst_timeout", timeout_err, 1'b0);
    checkOutput("rst_outst", dut.outstCnt_q, 4'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_core_rdy", core_req_rdy, 1'b1);

    // Single read with immediate ack
    out0_req_rdy = 1'b1;
    core_rsp_rdy = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h40, 10'h15, 32'h0, '0);
    checkOutput("rd_core_rdy", core_req_rdy, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 10'h0, 32'h0, '0);
    checkOutput("rd_req_vld", out0_req_vld, 1'b1);
    checkOutput("rd_req_addr", out0_req_addr, 32'h40);
    checkOutput("rd_req_sideband", out0_req_sideband, 10'h15);
    checkOutput("rd_req_opcode", out0_req_opcode, 1'b0);
    checkOutput("rd_req_src", out0_req_src_id, 4'd1);
    checkOutput("rd_req_tgt", out0_req_tgt_id, 4'd0);
    checkOutput("rd_outst1", dut.outstCnt_q, 4'd1);
    tick();
    checkOutput("rd_req_vld_drop", out0_req_vld, 1'b0);
    driveAck(1'b1, 4'd1, 10'h15, {8{32'hCAFE_0015}});
    checkOutput("rd_ack_rdy", out0_ack_rdy, 1'b1);
    tick();
    driveAck(1'b0, 4'd0, 10'h0, '0);
    checkOutput("rd_rsp_vld", core_rsp_vld, 1'b1);
    checkOutput("rd_rsp_tag", core_rsp_tag, 10'h15);
    checkOutput("rd_rsp_data", core_rsp_rdata, {8{32'hCAFE_0015}});
    checkOutput("rd_outst0", dut.outstCnt_q, 4'd0);
    checkOutput("rd_err_unexp", err_unexp, 1'b0);
    tick();
    checkOutput("rd_rsp_vld_drop", core_rsp_vld, 1'b0);

    // Five back-to-back reads with no acks; fifth must stall
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(i * 4), 10'h20 + 10'(i), 32'h0, '0);
      checkOutput($sformatf("b2b_rdy%0d", i), core_req_rdy, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) tick();
    end
    checkOutput("b2b_outst4", dut.outstCnt_q, 4'd4);
    tick();
    checkOutput("b2b_stall_rdy", core_req_rdy, 1'b0);

    // Full-strobe write while outstanding reads are at the limit
    applyStimulus(1'b1, 1'b1, 32'h200, 10'h3FF, 32'hFFFF_FFFF, wpat);
    checkOutput("wr_rdy_full", core_req_rdy, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h110, 10'h24, 32'h0, '0);
    checkOutput("wr_req_vld", out0_req_vld, 1'b1);
    checkOutput("wr_req_opcode", out0_req_opcode, 1'b1);
    checkOutput("wr_req_strb", out0_req_strb, 32'hFFFF_FFFF);
    checkOutput("wr_req_data", out0_req_data, wpat);
    checkOutput("wr_outst4", dut.outstCnt_q, 4'd4);
    checkOutput("wr_rd5_rdy", core_req_rdy, 1'b0);
    driveAck(1'b1, 4'd1, 10'h20, {8{32'hB0B0_0020}});
    checkOutput("ack_same_cycle_rdy", core_req_rdy, 1'b0);
    tick();
    driveAck(1'b0, 4'd0, 10'h0, '0);
    checkOutput("ack1_rsp_vld", core_rsp_vld, 1'b1);
    checkOutput("ack1_rsp_tag", core_rsp_tag, 10'h20);
    checkOutput("ack1_outst3", dut.outstCnt_q, 4'd3);
    checkOutput("rd5_rdy", core_req_rdy, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 10'h0, 32'h0, '0);
    checkOutput("rd5_outst4", dut.outstCnt_q, 4'd4);
    checkOutput("rd5_req_addr", out0_req_addr, 32'h110);

    // Drain remaining four reads with back-to-back acks
    for (int j = 0; j < 4; j++) begin
      driveAck(1'b1, 4'd1, 10'h21 + 10'(j), {8{32'(j)}});
      tick();
      checkOutput($sformatf("drain_tag%0d", j), core_rsp_tag, 10'h21 + 10'(j));
      checkOutput($sformatf("drain_vld%0d", j), core_rsp_vld, 1'b1);
      checkOutput($sformatf("drain_err%0d", j), err_unexp, 1'b0);
    end
    driveAck(1'b0, 4'd0, 10'h0, '0);
    checkOutput("drain_outst0", dut.outstCnt_q, 4'd0);

    // Bus back-pressure for three cycles
    out0_req_rdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 10'h2AA, 32'h0, '0);
    checkOutput("bp_rdy_empty", core_req_rdy, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h80, 10'h0C, 32'h0, '0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_vld%0d", k), out0_req_vld, 1'b1);
      checkOutput($sformatf("bp_addr%0d", k), out0_req_addr, 32'h1234_5678);
      checkOutput($sformatf("bp_tag%0d", k), out0_req_sideband, 10'h2AA);
      checkOutput($sformatf("bp_rdy%0d", k), core_req_rdy, 1'b0);
      tick();
    end
    out0_req_rdy = 1'b1;
    #1;
    checkOutput("bp_release_rdy", core_req_rdy, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 10'h0, 32'h0, '0);
    checkOutput("bp_next_addr", out0_req_addr, 32'h80);
    checkOutput("bp_next_tag", out0_req_sideband, 10'h0C);
    tick();
    checkOutput("bp_idle", out0_req_vld, 1'b0);
    checkOutput("bp_outst2", dut.outstCnt_q, 4'd2);
    driveAck(1'b1, 4'd1, 10'h2AA, '0);
    tick();
    driveAck(1'b1, 4'd1, 10'h0C, '0);
    tick();
    driveAck(1'b0, 4'd0, 10'h0, '0);
    checkOutput("bp_rsp_tag", core_rsp_tag, 10'h0C);
    checkOutput("bp_outst0", dut.outstCnt_q, 4'd0);

    // Unexpected acks: wrong target, then none outstanding
    driveAck(1'b1, 4'd2, 10'h55, {8{32'h1111_1111}});
    checkOutput("ux_ack_rdy", out0_ack_rdy, 1'b1);
    tick();
    checkOutput("ux_err1", err_unexp, 1'b1);
    checkOutput("ux_rsp1", core_rsp_vld, 1'b0);
    driveAck(1'b1, 4'd1, 10'h56, {8{32'h2222_2222}});
    tick();
    driveAck(1'b0, 4'd0, 10'h0, '0);
    checkOutput("ux_err2", err_unexp, 1'b1);
    checkOutput("ux_rsp2", core_rsp_vld, 1'b0);
    tick();
    checkOutput("ux_err_clr", err_unexp, 1'b0);
    checkOutput("ux_outst0", dut.outstCnt_q, 4'd0);

    // Watchdog: one read, never acknowledged
    applyStimulus(1'b1, 1'b0, 32'h300, 10'h1, 32'h0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 10'h0, 32'h0, '0);
    n = 0;
    while (!timeout_err && n < 1100) begin
      tick();
      n++;
    end
`ifdef TOY_BUS_INIT_TIMEOUT_EN
    checkOutput("to_set", timeout_err, 1'b1);
    checkOutput("to_cycles", n, 1025);
    repeat (20) tick();
`else
    checkOutput("to_off", timeout_err, 1'b0);
`endif
    driveAck(1'b1, 4'd1, 10'h1, '0);
    tick();
    driveAck(1'b0, 4'd0, 10'h0, '0);
    tick();
`ifdef TOY_BUS_INIT_TIMEOUT_EN
    checkOutput("to_held", timeout_err, 1'b1);
`else
    checkOutput("to_off_held", timeout_err, 1'b0);
`endif

    // Reset mid-operation abandons the in-flight read
    applyStimulus(1'b1, 1'b0, 32'h400, 10'h7, 32'h0, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 10'h0, 32'h0, '0);
    checkOutput("mid_outst1", dut.outstCnt_q, 4'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req_vld", out0_req_vld, 1'b0);
    checkOutput("mid_rst_outst", dut.outstCnt_q, 4'd0);
    checkOutput("mid_rst_timeout", timeout_err, 1'b0);
    tick();
    rst = 1'b0;
    driveAck(1'b1, 4'd1, 10'h7, '0);
    tick();
    driveAck(1'b0, 4'd0, 10'h0, '0);
    checkOutput("mid_late_err", err_unexp, 1'b1);
    checkOutput("mid_late_rsp", core_rsp_vld, 1'b0);
    checkOutput("mid_late_outst", dut.outstCnt_q, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
